// File: rtl/sysbus_pkg.sv
// System bus codes, cache line geometry and write-back buffer FSM states
// shared by dcache_wbbuf and its FIFO.
package sysbus_pkg;

    localparam int ADDR_W      = 64;
    localparam int OFFS_W      = 6;
    localparam int LTAG_W      = ADDR_W - OFFS_W;
    localparam int LINE_W      = 512;
    localparam int BEAT_W      = 64;
    localparam int BEATS       = LINE_W / BEAT_W;
    localparam int BEAT_CNT_W  = $clog2(BEATS);

    localparam logic [0:0] SYSBUS_WRITE  = 1'b1;
    localparam logic [3:0] SYSBUS_MEMORY = 4'h2;

    // Request tag for a memory write: command at bit 12, space at [11:8].
    localparam logic [12:0] SYSBUS_WR_MEM_TAG = {SYSBUS_WRITE, SYSBUS_MEMORY, 8'h00};

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ADDR,
        DATA,
        DONE
    } wbbuf_state_t;

endpackage

// File: rtl/dcache_wbbuf_fifo.sv
// Circular store of evicted dirty lines; exposes every slot so the top can
// run the conflict lookup and stream the head entry onto the bus.
module dcache_wbbuf_fifo
    import sysbus_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                push_en,
    input  logic [LTAG_W-1:0]                   push_tag,
    input  logic [LINE_W-1:0]                   push_line,
    input  logic                                pop_en,
    output logic [$clog2(DEPTH):0]              count,
    output logic [$clog2(DEPTH)-1:0]            rd_ptr,
    output logic [DEPTH-1:0][LTAG_W-1:0]        ent_tag,
    output logic [DEPTH-1:0][LINE_W-1:0]        ent_line
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]              count_q, count_d;
    logic [DEPTH-1:0][LTAG_W-1:0]  tag_q, tag_d;
    logic [DEPTH-1:0][LINE_W-1:0]  line_q, line_d;
    logic                          push_ok, pop_ok;

    always_comb begin
        push_ok  = push_en && (count_q < CNT_W'(DEPTH));
        pop_ok   = pop_en && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        tag_d    = tag_q;
        line_d   = line_q;
        if (push_ok) begin
            tag_d[wr_ptr_q]  = push_tag;
            line_d[wr_ptr_q] = push_line;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset: count gates every consumer of a slot.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        line_q <= line_d;
    end

    assign count    = count_q;
    assign rd_ptr   = rd_ptr_q;
    assign ent_tag  = tag_q;
    assign ent_line = line_q;

endmodule

// File: rtl/dcache_wbbuf.sv
// Data cache write-back buffer: queues evicted dirty lines and writes them
// to memory as address + 8-beat bursts. Define DCACHE_WBBUF_FWD_EN to
// forward buffered line data on a lookup hit.
module dcache_wbbuf
    import sysbus_pkg::*;
#(
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int DEPTH          = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wb_valid,
    input  logic [63:0]               wb_addr,
    input  logic [511:0]              wb_line,
    output logic                      wb_ready,
    input  logic [63:0]               lookup_addr,
    output logic                      lookup_hit,
    output logic [511:0]              lookup_line,
    output logic                      wb_busreq,
    input  logic                      wb_busgrant,
    output logic                      wb_busidle,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    output logic                      wbbuf_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wbbuf_state_t                  state_q, state_d;
    logic [BEAT_CNT_W-1:0]         beat_q, beat_d;
    logic                          pop;
    logic [CNT_W-1:0]              count;
    logic [PTR_W-1:0]              rd_ptr;
    logic [DEPTH-1:0][LTAG_W-1:0]  ent_tag;
    logic [DEPTH-1:0][LINE_W-1:0]  ent_line;
    logic [LTAG_W-1:0]             head_tag;
    logic [LINE_W-1:0]             head_line;
    logic [PTR_W-1:0]              idx;
    logic [PTR_W-1:0]              hit_idx;
    logic                          unused_ok;

    dcache_wbbuf_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_en  (wb_valid),
        .push_tag (wb_addr[63:OFFS_W]),
        .push_line(wb_line),
        .pop_en   (pop),
        .count    (count),
        .rd_ptr   (rd_ptr),
        .ent_tag  (ent_tag),
        .ent_line (ent_line)
    );

    assign head_tag    = ent_tag[rd_ptr];
    assign head_line   = ent_line[rd_ptr];
    assign wb_ready    = count < CNT_W'(DEPTH);
    assign wbbuf_empty = count == '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        pop        = 1'b0;
        wb_busreq  = 1'b0;
        wb_busidle = 1'b0;
        bus_reqcyc = 1'b0;
        bus_req    = '0;
        bus_reqtag = '0;
        case (state_q)
            IDLE: begin
                wb_busidle = 1'b1;
                if (count != '0) state_d = ARB;
            end
            ARB: begin
                wb_busreq = 1'b1;
                if (wb_busgrant) state_d = ADDR;
            end
            ADDR: begin
                bus_reqcyc = 1'b1;
                bus_req    = BUS_DATA_WIDTH'({head_tag, {OFFS_W{1'b0}}});
                bus_reqtag = BUS_TAG_WIDTH'(SYSBUS_WR_MEM_TAG);
                if (bus_reqack) begin
                    state_d = DATA;
                    beat_d  = '0;
                end
            end
            DATA: begin
                bus_reqcyc = 1'b1;
                bus_req    = BUS_DATA_WIDTH'(head_line[beat_q*BEAT_W +: BEAT_W]);
                if (beat_q == BEAT_CNT_W'(BEATS - 1)) state_d = DONE;
                else                                  beat_d  = beat_q + BEAT_CNT_W'(1);
            end
            DONE: begin
                // Head stays visible to lookup until this edge retires it.
                pop     = 1'b1;
                beat_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan oldest to newest so the youngest matching entry wins.
    always_comb begin
        lookup_hit = 1'b0;
        hit_idx    = '0;
        idx        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if ((CNT_W'(k) < count) && (ent_tag[idx] == lookup_addr[63:OFFS_W])) begin
                lookup_hit = 1'b1;
                hit_idx    = idx;
            end
        end
    end

`ifdef DCACHE_WBBUF_FWD_EN
    assign lookup_line = lookup_hit ? ent_line[hit_idx] : '0;
    assign unused_ok   = ^{wb_addr[OFFS_W-1:0], lookup_addr[OFFS_W-1:0]};
`else
    assign lookup_line = '0;
    assign unused_ok   = ^{wb_addr[OFFS_W-1:0], lookup_addr[OFFS_W-1:0], hit_idx};
`endif

endmodule

// File: tb/tb_dcache_wbbuf.sv
// Randomized bench for dcache_wbbuf against a queue-based reference of the
// buffer contents and the bus transaction sequence.
module tb_dcache_wbbuf;

    localparam int TW    = 13;
    localparam int DW    = 64;
    localparam int DEPTH = 2;
    localparam logic [TW-1:0] EXP_TAG = 13'h1200;

    logic            clk = 1'b0;
    logic            reset;
    logic            wb_valid;
    logic [63:0]     wb_addr;
    logic [511:0]    wb_line;
    logic            wb_ready;
    logic [63:0]     lookup_addr;
    logic            lookup_hit;
    logic [511:0]    lookup_line;
    logic            wb_busreq;
    logic            wb_busgrant;
    logic            wb_busidle;
    logic            bus_reqcyc;
    logic [DW-1:0]   bus_req;
    logic [TW-1:0]   bus_reqtag;
    logic            bus_reqack;
    logic            wbbuf_empty;

    dcache_wbbuf #(
        .BUS_TAG_WIDTH (TW),
        .BUS_DATA_WIDTH(DW),
        .DEPTH         (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_line    (wb_line),
        .wb_ready   (wb_ready),
        .lookup_addr(lookup_addr),
        .lookup_hit (lookup_hit),
        .lookup_line(lookup_line),
        .wb_busreq  (wb_busreq),
        .wb_busgrant(wb_busgrant),
        .wb_busidle (wb_busidle),
        .bus_reqcyc (bus_reqcyc),
        .bus_req    (bus_req),
        .bus_reqtag (bus_reqtag),
        .bus_reqack (bus_reqack),
        .wbbuf_empty(wbbuf_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [57:0]  tag;
        logic [511:0] line;
    } ent_t;

    typedef enum {B_QUIET, B_WANT, B_ADDR, B_BEAT, B_FIN} bph_t;

    ent_t  q[$];
    bph_t  ph;
    int    beat;
    int    wait_cnt;
    int    g_dly;
    int    a_dly;
    int    checks;
    int    fails;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [63:0] rand_addr();
        return 64'h8000_0000 + 64'($urandom_range(0, 3) << 6) + 64'($urandom_range(0, 63));
    endfunction

    // One clock: drive at posedge+1, check at posedge+4, advance reference after the edge.
    task automatic step(input bit v, input logic [63:0] a, input logic [511:0] l, input logic [63:0] la);
        bit           acc, gnt, ack, hit;
        logic [511:0] hl;
        logic [63:0]  eb;
        logic [TW-1:0] et;
        wb_valid    = v;
        wb_addr     = a;
        wb_line     = l;
        lookup_addr = la;
        gnt = (ph == B_WANT) ? (wait_cnt >= g_dly) : ($urandom_range(0, 3) == 0);
        ack = (ph == B_ADDR) ? (wait_cnt >= a_dly) : ($urandom_range(0, 3) == 0);
        wb_busgrant = gnt;
        bus_reqack  = ack;
        #3;
        chk("wb_ready", wb_ready, q.size() < DEPTH);
        chk("empty", wbbuf_empty, q.size() == 0);
        hit = 1'b0;
        hl  = '0;
        foreach (q[i]) if (q[i].tag == la[63:6]) begin hit = 1'b1; hl = q[i].line; end
`ifndef DCACHE_WBBUF_FWD_EN
        hl = '0;
`endif
        chk("lookup_hit", lookup_hit, hit);
        chk("lookup_line", lookup_line, hl);
        chk("busreq", wb_busreq, ph == B_WANT);
        chk("busidle", wb_busidle, ph == B_QUIET);
        chk("reqcyc", bus_reqcyc, (ph == B_ADDR) || (ph == B_BEAT));
        eb = '0;
        et = '0;
        if (ph == B_ADDR) begin eb = {q[0].tag, 6'b0}; et = EXP_TAG; end
        if (ph == B_BEAT) eb = q[0].line[64*beat +: 64];
        chk("bus_req", bus_req, eb);
        chk("bus_reqtag", bus_reqtag, et);
        acc = v && (q.size() < DEPTH);
        @(posedge clk);
        #1;
        case (ph)
            B_QUIET: if (q.size() > 0) begin ph = B_WANT; wait_cnt = 0; end
            B_WANT:  if (gnt) begin ph = B_ADDR; wait_cnt = 0; end else wait_cnt++;
            B_ADDR:  if (ack) begin ph = B_BEAT; beat = 0; end else wait_cnt++;
            B_BEAT:  if (beat == 7) ph = B_FIN; else beat++;
            B_FIN:   begin void'(q.pop_front()); ph = B_QUIET; end
            default: ph = B_QUIET;
        endcase
        if (acc) q.push_back('{tag: a[63:6], line: l});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, rand_addr(), '0, rand_addr());
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (!(q.size() == 0 && ph == B_QUIET) && n < max) begin
            step(1'b0, rand_addr(), '0, rand_addr());
            n++;
        end
        if (n >= max) chk("drain_timeout", 1'b0, 1'b1);
        idle(1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        chk("rst_reqcyc", bus_reqcyc, 1'b0);
        chk("rst_ready", wb_ready, 1'b1);
        chk("rst_empty", wbbuf_empty, 1'b1);
        chk("rst_hit", lookup_hit, 1'b0);
        chk("rst_line", lookup_line, 512'd0);
        chk("rst_busreq", wb_busreq, 1'b0);
        chk("rst_busidle", wb_busidle, 1'b1);
        chk("rst_bus_req", bus_req, 64'd0);
        chk("rst_reqtag", bus_reqtag, 13'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        q.delete();
        ph = B_QUIET;
        wait_cnt = 0;
        beat = 0;
    endtask

    initial begin
        logic [511:0] l0, la_, lb_;
        int n;
        checks = 0;
        fails  = 0;
        wb_valid = 0; wb_addr = 0; wb_line = 0; lookup_addr = 0;
        wb_busgrant = 0; bus_reqack = 0;
        g_dly = 0; a_dly = 0;
        reset = 1'b1;
        #1;
        do_reset();

        // Single line: beats 0x11..0x88, grant after 2, ack after 3.
        for (int i = 0; i < 8; i++) l0[64*i +: 64] = 64'((i + 1) * 'h11);
        g_dly = 2; a_dly = 3;
        step(1'b1, 64'h1000_0047, l0, 64'h1000_0000);
        drain(40);
        chk("single_empty", wbbuf_empty, 1'b1);

        // Fill with no grant, extra push ignored, then drain in order.
        g_dly = 100000;
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, rand_addr(), rand_line(), rand_addr());
        chk("full_size", q.size(), DEPTH);
        idle(3);
        g_dly = 0; a_dly = 0;
        drain(100);

        // Same line pushed twice; newest data must win.
        g_dly = 100000;
        la_ = rand_line();
        lb_ = rand_line();
        step(1'b1, 64'h2000, la_, 64'h2008);
        step(1'b1, 64'h2000, lb_, 64'h2008);
        step(1'b0, 64'h0, '0, 64'h2008);
        chk("dup_hit", lookup_hit, 1'b1);
`ifdef DCACHE_WBBUF_FWD_EN
        chk("dup_line", lookup_line, lb_);
`else
        chk("dup_line", lookup_line, 512'd0);
`endif
        g_dly = 0;
        drain(100);

        // Continuous push pressure: pushes collide with DONE pops at full.
        g_dly = 0; a_dly = 0;
        for (int i = 0; i < 60; i++) step(1'b1, rand_addr(), rand_line(), rand_addr());
        drain(100);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if (ph == B_QUIET) begin
                g_dly = $urandom_range(0, 3);
                a_dly = $urandom_range(0, 3);
            end
            step($urandom_range(0, 2) == 0, rand_addr(), rand_line(), rand_addr());
        end
        drain(100);

        // Reset during beat 3 aborts the burst and loses buffered lines.
        g_dly = 0; a_dly = 1;
        step(1'b1, rand_addr(), rand_line(), rand_addr());
        step(1'b1, rand_addr(), rand_line(), rand_addr());
        n = 0;
        while (!(ph == B_BEAT && beat == 3) && n < 40) begin
            step(1'b0, rand_addr(), '0, rand_addr());
            n++;
        end
        if (n >= 40) chk("beat3_timeout", 1'b0, 1'b1);
        do_reset();
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
